// File: rtl/wb_spi_flash_ctrl_if.sv
// Wishbone classic read port and SPI flash pins for wb_spi_flash_ctrl.
// The slave modport is the controller; the master modport is the SoC side and flash.
interface wb_spi_flash_ctrl_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        spi_sck_o;
   logic        spi_cs_n_o;
   logic        spi_mosi_o;
   logic        spi_miso_i;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o,
      output spi_sck_o, spi_cs_n_o, spi_mosi_o,
      input  spi_miso_i
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o,
      input  spi_sck_o, spi_cs_n_o, spi_mosi_o,
      output spi_miso_i
   );
endinterface

// File: rtl/wb_spi_flash_ctrl.sv
// Read-only Wishbone slave issuing one SPI READ (0x03) frame per word.
// Mode 0 SCK; every output is registered.
module wb_spi_flash_ctrl #(
   parameter int CLK_DIV = 2
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   wb_spi_flash_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT, ACK, HOLD, ERR
   } state_t;

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   state_t      state, state_n;
   logic [7:0]  div_cnt, div_n;
   logic [6:0]  bit_cnt, bit_n;
   logic [31:0] tx, tx_n;
   logic [31:0] rx, rx_n;
   logic [31:0] dat, dat_n;
   logic        sck, sck_n;
   logic        cs_n, cs_n_n;
   logic        mosi, mosi_n;
   logic        ack, ack_n;
   logic        err, err_n;

   logic tick;
   logic req;
   logic last;
   logic unused_bits;

   assign tick = (div_cnt == DIV_M1);
   assign req  = bus.wb_cyc_i & bus.wb_stb_i & ~ack & ~err;
   assign last = (bit_cnt == 7'd64);

   assign unused_bits = ^{bus.wb_dat_i, bus.wb_sel_i,
                          bus.wb_adr_i[31:24], bus.wb_adr_i[1:0]};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (req) state_n = bus.wb_we_i ? ERR : SETUP;
         SETUP:   if (tick) state_n = SHIFT;
         SHIFT:   if (tick && !sck && last) state_n = ACK;
         ACK:     state_n = HOLD;
         HOLD:    if (tick) state_n = IDLE;
         ERR:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      div_n  = div_cnt;
      bit_n  = bit_cnt;
      tx_n   = tx;
      rx_n   = rx;
      dat_n  = dat;
      sck_n  = sck;
      cs_n_n = cs_n;
      mosi_n = mosi;
      ack_n  = 1'b0;
      err_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (req && bus.wb_we_i) begin
               err_n = 1'b1;
            end else if (req) begin
               tx_n   = {8'h03, bus.wb_adr_i[23:2], 2'b00};
               bit_n  = 7'd0;
               div_n  = 8'd0;
               cs_n_n = 1'b0;
               mosi_n = tx_n[31];
            end
         end
         SETUP: begin
            div_n = tick ? 8'd0 : div_cnt + 8'd1;
            if (tick) sck_n = 1'b1;
         end
         SHIFT: begin
            div_n = tick ? 8'd0 : div_cnt + 8'd1;
            if (tick && sck) begin
               sck_n  = 1'b0;
               tx_n   = {tx[30:0], 1'b0};
               mosi_n = tx[30];
               bit_n  = bit_cnt + 7'd1;
            end else if (tick && last) begin
               cs_n_n = 1'b1;
               mosi_n = 1'b0;
               dat_n  = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
               ack_n  = bus.wb_cyc_i & bus.wb_stb_i;
            end else if (tick) begin
               sck_n = 1'b1;
               // first 32 periods clock out the command; their MISO is junk
               if (bit_cnt[5]) rx_n = {rx[30:0], bus.spi_miso_i};
            end
         end
         ACK: div_n = 8'd0;
         HOLD: div_n = tick ? 8'd0 : div_cnt + 8'd1;
         ERR: ;
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         div_cnt <= 8'd0;
         bit_cnt <= 7'd0;
         tx      <= 32'd0;
         rx      <= 32'd0;
         dat     <= 32'd0;
         sck     <= 1'b0;
         cs_n    <= 1'b1;
         mosi    <= 1'b0;
         ack     <= 1'b0;
         err     <= 1'b0;
      end else begin
         div_cnt <= div_n;
         bit_cnt <= bit_n;
         tx      <= tx_n;
         rx      <= rx_n;
         dat     <= dat_n;
         sck     <= sck_n;
         cs_n    <= cs_n_n;
         mosi    <= mosi_n;
         ack     <= ack_n;
         err     <= err_n;
      end
   end

   assign bus.wb_dat_o   = dat;
   assign bus.wb_ack_o   = ack;
   assign bus.wb_err_o   = err;
   assign bus.spi_sck_o  = sck;
   assign bus.spi_cs_n_o = cs_n;
   assign bus.spi_mosi_o = mosi;

endmodule

// File: tb/tb_wb_spi_flash_ctrl.sv
// Directed bench for wb_spi_flash_ctrl at CLK_DIV=2 and CLK_DIV=1,
// with a behavioural SPI flash attached to each instance.
module tb_wb_spi_flash_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wb_spi_flash_ctrl_if if2 ();
   wb_spi_flash_ctrl_if if1 ();

   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic        dsel = 1'b0;
   logic [31:0] adr = 32'd0;
   logic [31:0] resp = 32'd0;

   int checks = 0;
   int errors = 0;

   assign if2.wb_cyc_i = cyc & ~dsel;
   assign if2.wb_stb_i = stb & ~dsel;
   assign if2.wb_we_i  = we;
   assign if2.wb_adr_i = adr;
   assign if2.wb_dat_i = 32'hA5A5A5A5;
   assign if2.wb_sel_i = 4'hF;
   assign if1.wb_cyc_i = cyc & dsel;
   assign if1.wb_stb_i = stb & dsel;
   assign if1.wb_we_i  = we;
   assign if1.wb_adr_i = adr;
   assign if1.wb_dat_i = 32'h5A5A5A5A;
   assign if1.wb_sel_i = 4'h0;

   wb_spi_flash_ctrl #(.CLK_DIV(2)) u2 (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (if2)
   );

   wb_spi_flash_ctrl #(.CLK_DIV(1)) u1 (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (if1)
   );

   logic        ack, err, sck, csn, mosi;
   logic [31:0] dat;
   assign ack  = dsel ? if1.wb_ack_o   : if2.wb_ack_o;
   assign err  = dsel ? if1.wb_err_o   : if2.wb_err_o;
   assign sck  = dsel ? if1.spi_sck_o  : if2.spi_sck_o;
   assign csn  = dsel ? if1.spi_cs_n_o : if2.spi_cs_n_o;
   assign mosi = dsel ? if1.spi_mosi_o : if2.spi_mosi_o;
   assign dat  = dsel ? if1.wb_dat_o   : if2.wb_dat_o;

   // flash model: command bits captured on SCK rise, data driven on SCK fall
   int          rc2 = 0, rises2 = 0, stray2 = 0;
   logic [31:0] cmd2 = 32'd0;
   logic        psck2 = 1'b0, pcs2 = 1'b1;
   always @(if2.spi_sck_o, if2.spi_cs_n_o) begin
      if (if2.spi_cs_n_o !== pcs2) begin
         if (if2.spi_cs_n_o) rises2 = rc2;
         rc2 = 0;
      end
      if (if2.spi_sck_o && !psck2) begin
         if (if2.spi_cs_n_o) stray2++;
         else begin
            if (rc2 < 32) cmd2 = {cmd2[30:0], if2.spi_mosi_o};
            rc2++;
         end
      end
      if (!if2.spi_sck_o && psck2 && !if2.spi_cs_n_o && rc2 >= 32 && rc2 < 64)
         if2.spi_miso_i = resp[63-rc2];
      psck2 = if2.spi_sck_o;
      pcs2  = if2.spi_cs_n_o;
   end

   int          rc1 = 0, rises1 = 0, stray1 = 0;
   logic [31:0] cmd1 = 32'd0;
   logic        psck1 = 1'b0, pcs1 = 1'b1;
   always @(if1.spi_sck_o, if1.spi_cs_n_o) begin
      if (if1.spi_cs_n_o !== pcs1) begin
         if (if1.spi_cs_n_o) rises1 = rc1;
         rc1 = 0;
      end
      if (if1.spi_sck_o && !psck1) begin
         if (if1.spi_cs_n_o) stray1++;
         else begin
            if (rc1 < 32) cmd1 = {cmd1[30:0], if1.spi_mosi_o};
            rc1++;
         end
      end
      if (!if1.spi_sck_o && psck1 && !if1.spi_cs_n_o && rc1 >= 32 && rc1 < 64)
         if1.spi_miso_i = resp[63-rc1];
      psck1 = if1.spi_sck_o;
      pcs1  = if1.spi_cs_n_o;
   end

   int ack_cnt2 = 0;
   int hi_run = 0;
   int last_gap = 0;
   always @(negedge clk) begin
      if (if2.wb_ack_o) ack_cnt2++;
      if (csn) hi_run++;
      else begin
         if (hi_run > 0) last_gap = hi_run;
         hi_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, input int drop_at,
                     output int ack_at, output int rise_at,
                     output logic [31:0] d);
      bit low;
      low = 1'b0;
      @(negedge clk);
      adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      ack_at = -1;
      rise_at = -1;
      for (int k = 1; k <= 400 && rise_at < 0; k++) begin
         @(posedge clk); #1;
         if (!csn) low = 1'b1;
         if (ack && ack_at < 0) begin
            ack_at = k; cyc = 1'b0; stb = 1'b0;
         end
         if (k == drop_at) begin
            cyc = 1'b0; stb = 1'b0;
         end
         if (low && csn) rise_at = k;
      end
      cyc = 1'b0; stb = 1'b0;
      d = dat;
   endtask

   initial begin
      int ack_at, rise_at, err_at, err_n, acks0;
      logic [31:0] d;
      bit bad;
      if2.spi_miso_i = 1'b0;
      if1.spi_miso_i = 1'b0;

      #2 rst = 1'b1;
      #3;
      chk("rst dat", dat, 32'd0);
      chk("rst ack", {31'd0, ack}, 32'd0);
      chk("rst err", {31'd0, err}, 32'd0);
      chk("rst sck", {31'd0, sck}, 32'd0);
      chk("rst csn", {30'd0, if1.spi_cs_n_o, csn}, 32'd3);
      chk("rst mosi", {31'd0, mosi}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      resp = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      rd(32'h0000_0100, 0, ack_at, rise_at, d);
      chk("rd cmd", cmd2, 32'h0300_0100);
      chk("rd data", d, 32'hDEAD_BEEF);
      chk("rd ack cycle", ack_at, 32'd259);
      chk("rd cs rise", rise_at, 32'd259);
      chk("rd sck rises", rises2, 32'd64);
      chk("rd stray sck", stray2, 32'd0);

      repeat (4) @(negedge clk);
      resp = 32'h1234_5678;
      rd(32'h20FF_FFFE, 0, ack_at, rise_at, d);
      chk("mask cmd", cmd2, 32'h03FF_FFFC);
      chk("mask data", d, 32'h7856_3412);

      repeat (4) @(negedge clk);
      adr = 32'd0; we = 1'b1; cyc = 1'b1; stb = 1'b1;
      err_at = -1; err_n = 0; bad = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (err && err_at < 0) err_at = k;
         if (err) err_n++;
         if (k == 1) begin
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
         end
         if (ack || !csn || sck) bad = 1'b1;
      end
      chk("wr err cycle", err_at, 32'd1);
      chk("wr err width", err_n, 32'd1);
      chk("wr no spi/ack", {31'd0, bad}, 32'd0);

      @(negedge clk);
      adr = 32'd0; we = 1'b0; cyc = 1'b1; stb = 1'b1;
      acks0 = ack_cnt2;
      repeat (83) @(posedge clk);
      #1;
      chk("mid sck high", {31'd0, sck}, 32'd1);
      chk("mid bits in", rc2, 32'd21);
      #2 rst = 1'b1;
      #1;
      chk("mid rst sck/csn", {30'd0, sck, csn}, 32'd1);
      cyc = 1'b0; stb = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid no ack", ack_cnt2 - acks0, 32'd0);

      resp = {8'h11, 8'h22, 8'h33, 8'h44};
      rd(32'h0000_0004, 0, ack_at, rise_at, d);
      chk("post rst cmd", cmd2, 32'h0300_0004);
      chk("post rst data", d, 32'h4433_2211);
      chk("post rst ack", ack_at, 32'd259);

      repeat (4) @(negedge clk);
      acks0 = ack_cnt2;
      resp = 32'hCAFE_F00D;
      rd(32'h0000_0040, 163, ack_at, rise_at, d);
      chk("abort ack", ack_at, 32'hFFFF_FFFF);
      chk("abort cs rise", rise_at, 32'd259);
      chk("abort rises", rises2, 32'd64);
      chk("abort ack cnt", ack_cnt2 - acks0, 32'd0);

      resp = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
      rd(32'h0000_0080, 0, ack_at, rise_at, d);
      chk("b2b gap0", {31'd0, last_gap >= 3}, 32'd1);
      chk("b2b data0", d, 32'hD4C3_B2A1);
      resp = {8'h0F, 8'h1E, 8'h2D, 8'h3C};
      rd(32'h0000_0084, 0, ack_at, rise_at, d);
      chk("b2b gap1", {31'd0, last_gap >= 3}, 32'd1);
      chk("b2b data1", d, 32'h3C2D_1E0F);
      chk("b2b cmd1", cmd2, 32'h0300_0084);

      repeat (6) @(negedge clk);
      dsel = 1'b1;
      repeat (2) @(negedge clk);
      resp = {8'h01, 8'h02, 8'h03, 8'h04};
      rd(32'h0000_0010, 0, ack_at, rise_at, d);
      chk("h1 cmd", cmd1, 32'h0300_0010);
      chk("h1 data", d, 32'h0403_0201);
      chk("h1 ack cycle", ack_at, 32'd130);
      chk("h1 sck rises", rises1, 32'd64);
      chk("h1 stray sck", stray1, 32'd0);

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
